// File: rtl/i2s_codec_responder.sv
// i2s_codec_responder: codec-side I2S bus master used for on-chip loopback.
// Generates BCLK/LRCK from clkIn, serializes a buffered stereo sample onto
// ADCDAT and deserializes DACDAT into parallel samples, with the standard
// one-bit I2S delay after every LRCK transition.
module i2s_codec_responder #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_BITS  = 32,
   parameter int BCLK_DIV   = 4
) (
   input  logic                  clkIn,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_left,
   input  logic [DATA_WIDTH-1:0] tx_right,
   output logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] rx_left,
   output logic [DATA_WIDTH-1:0] rx_right,
   output logic                  underrun,
   output logic                  busy,
   output logic                  BCLK,
   output logic                  LRCK,
   output logic                  ADCDAT,
   input  logic                  DACDAT
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int POS_W      = $clog2(FRAME_BITS);
   localparam int DIV_W      = $clog2(BCLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_BITS - 1);
   localparam logic [POS_W-1:0] SLOT_P   = POS_W'(SLOT_BITS);
   localparam logic [POS_W-1:0] DW_P     = POS_W'(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   state_e                state_q,      state_d;
   logic [DIV_W-1:0]      div_q,        div_d;
   logic [POS_W-1:0]      pos_q,        pos_d;
   logic                  bclk_q,       bclk_d;
   logic                  lrck_q,       lrck_d;
   logic                  adc_q,        adc_d;
   logic                  hold_full_q,  hold_full_d;
   logic [DATA_WIDTH-1:0] hold_l_q,     hold_l_d;
   logic [DATA_WIDTH-1:0] hold_r_q,     hold_r_d;
   logic [DATA_WIDTH-1:0] shift_l_q,    shift_l_d;
   logic [DATA_WIDTH-1:0] shift_r_q,    shift_r_d;
   logic [DATA_WIDTH-1:0] cap_l_q,      cap_l_d;
   logic [DATA_WIDTH-1:0] cap_r_q,      cap_r_d;
   logic [DATA_WIDTH-1:0] rx_left_q,    rx_left_d;
   logic [DATA_WIDTH-1:0] rx_right_q,   rx_right_d;
   logic                  rx_valid_q,   rx_valid_d;
   logic                  underrun_q,   underrun_d;

   // Edge strobes: a BCLK edge happens when the divider reaches its last count.
   logic             tick, fall_edge, rise_edge;
   logic             fall_slot, rise_slot;
   logic [POS_W-1:0] fall_k, rise_k, prev_pos;

   assign tick      = (state_q != IDLE) && (div_q == DIV_LAST);
   assign fall_edge = tick &&  bclk_q;
   assign rise_edge = tick && !bclk_q;

   // The falling edge drives position pos_q; the rising edge samples the bit
   // driven by the preceding falling edge, i.e. position pos_q-1.
   assign fall_slot = (pos_q >= SLOT_P);
   assign fall_k    = fall_slot ? (pos_q - SLOT_P) : pos_q;
   assign prev_pos  = (pos_q == '0) ? POS_LAST : (pos_q - 1'b1);
   assign rise_slot = (prev_pos >= SLOT_P);
   assign rise_k    = rise_slot ? (prev_pos - SLOT_P) : prev_pos;

   assign tx_ready = !hold_full_q;
   assign rx_valid = rx_valid_q;
   assign rx_left  = rx_left_q;
   assign rx_right = rx_right_q;
   assign underrun = underrun_q;
   assign busy     = (state_q != IDLE);
   assign BCLK     = bclk_q;
   assign LRCK     = lrck_q;
   assign ADCDAT   = adc_q;

   // Next-state logic: FSM, bit-clock divider, serializer, deserializer, tx buffer.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path through this block
      // leaves a variable unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      div_d       = div_q;
      pos_d       = pos_q;
      bclk_d      = bclk_q;
      lrck_d      = lrck_q;
      adc_d       = adc_q;
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      shift_l_d   = shift_l_q;
      shift_r_d   = shift_r_q;
      cap_l_d     = cap_l_q;
      cap_r_d     = cap_r_q;
      rx_left_d   = rx_left_q;
      rx_right_d  = rx_right_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;

      if (state_q == IDLE) begin
         bclk_d = 1'b0;
         lrck_d = 1'b1;
         div_d  = '0;
         pos_d  = '0;
         if (enable) state_d = RUN;
      end else begin
         div_d = tick ? '0 : (div_q + 1'b1);
         if (tick) bclk_d = !bclk_q;
         if (enable) begin
            state_d = RUN;
         end else if (state_q == RUN) begin
            state_d = STOP;
         end else if (fall_edge && (pos_q == POS_LAST)) begin
            state_d = IDLE;
            lrck_d  = 1'b1;
         end
      end

      // Falling edge: drive LRCK/ADCDAT for position pos_q, reload at frame start.
      if (fall_edge) begin
         if (fall_k == '0) begin
            lrck_d = fall_slot;
            adc_d  = 1'b0;
         end else if (fall_k <= DW_P) begin
            if (fall_slot) begin
               adc_d     = shift_r_q[DATA_WIDTH-1];
               shift_r_d = shift_r_q << 1;
            end else begin
               adc_d     = shift_l_q[DATA_WIDTH-1];
               shift_l_d = shift_l_q << 1;
            end
         end else begin
            adc_d = 1'b0;
         end

         if (pos_q == '0) begin
            if (hold_full_q) begin
               shift_l_d   = hold_l_q;
               shift_r_d   = hold_r_q;
               hold_full_d = 1'b0;
            end else begin
               shift_l_d  = '0;
               shift_r_d  = '0;
               underrun_d = 1'b1;
            end
         end

         pos_d = (pos_q == POS_LAST) ? '0 : (pos_q + 1'b1);
      end

      // Rising edge: capture DACDAT MSB first; publish after the last right bit.
      if (rise_edge && (rise_k != '0) && (rise_k <= DW_P)) begin
         if (rise_slot) begin
            cap_r_d = DATA_WIDTH'({cap_r_q, DACDAT});
            if (rise_k == DW_P) begin
               rx_left_d  = cap_l_q;
               rx_right_d = DATA_WIDTH'({cap_r_q, DACDAT});
               rx_valid_d = 1'b1;
            end
         end else begin
            cap_l_d = DATA_WIDTH'({cap_l_q, DACDAT});
         end
      end

      // A transfer only happens into an empty holding register, so a frame-start
      // unload in the same cycle sees it empty and the new sample stays held.
      if (tx_valid && !hold_full_q) begin
         hold_l_d    = tx_left;
         hold_r_d    = tx_right;
         hold_full_d = 1'b1;
      end
   end

   // State register; reset aborts any frame and discards partial captures.
   always_ff @(posedge clkIn or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         // NOTE: the sample buffers are plain flops, not RAM, so they are reset
         // too; a published rx sample can never expose stale capture bits.
         state_q     <= IDLE;
         div_q       <= '0;
         pos_q       <= '0;
         bclk_q      <= 1'b0;
         lrck_q      <= 1'b1;
         adc_q       <= 1'b0;
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         shift_l_q   <= '0;
         shift_r_q   <= '0;
         cap_l_q     <= '0;
         cap_r_q     <= '0;
         rx_left_q   <= '0;
         rx_right_q  <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         pos_q       <= pos_d;
         bclk_q      <= bclk_d;
         lrck_q      <= lrck_d;
         adc_q       <= adc_d;
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         shift_l_q   <= shift_l_d;
         shift_r_q   <= shift_r_d;
         cap_l_q     <= cap_l_d;
         cap_r_q     <= cap_r_d;
         rx_left_q   <= rx_left_d;
         rx_right_q  <= rx_right_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
      end
   end

endmodule
